// File: rtl/branch_resolve_pkg.sv
// Shared pipeline definitions for the Execute-stage branch resolution unit:
// default widths and the Decode-to-Execute branch record.
package branch_resolve_pkg;

  localparam int DEF_IDX_W = 6;
  localparam int DEF_PC_W  = 32;
  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 pred;
    logic [DEF_IDX_W-1:0] addr;
    logic [DEF_PC_W-1:0]  pc_plus4;
    logic [DEF_PC_W-1:0]  target;
  } br_fields_t;

  localparam br_fields_t BR_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Enable-increment counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: checks the 1-bit prediction against the
// real outcome, updates branch history, redirects fetch and keeps statistics.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  // IDX_W and PC_W must match the package record widths.
  parameter int IDX_W = DEF_IDX_W,
  parameter int PC_W  = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             branchD,
  input  logic             predD,
  input  logic [IDX_W-1:0] addrD,
  input  logic [PC_W-1:0]  pcPlus4D,
  input  logic [PC_W-1:0]  targetD,
  input  logic             takenE,
  output logic             predTakenD,
  output logic             we,
  output logic             wd,
  output logic [IDX_W-1:0] addrE,
  output logic             mispredE,
  output logic [PC_W-1:0]  redirectPC,
  output logic             flushD,
  output logic [CNT_W-1:0] brCount,
  output logic [CNT_W-1:0] missCount
);

  br_fields_t e_q;
  br_fields_t e_d;
  logic       v_e;

  // A stalled branch is held, not resolved; it resolves on its first free cycle.
  assign v_e = e_q.valid & ~stallE;

  assign we         = v_e;
  assign wd         = takenE;
  assign addrE      = e_q.addr;
  assign mispredE   = v_e & (e_q.pred ^ takenE);
  assign redirectPC = takenE ? e_q.target : e_q.pc_plus4;
  assign flushD     = mispredE;

  // The history memory only commits at the edge, so a Decode read of the
  // entry being written this cycle must see the new value directly.
  assign predTakenD = (we && (addrE == addrD)) ? wd : predD;

  // NOTE: e_d gets a full default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    e_d = e_q;
    if (!stallE) begin
      if (flushE || mispredE) begin
        // Squash: the instruction behind a mispredicted branch is wrong-path.
        e_d = BR_BUBBLE;
      end else begin
        e_d.valid    = branchD;
        e_d.pred     = predTakenD;
        e_d.addr     = addrD;
        e_d.pc_plus4 = pcPlus4D;
        e_d.target   = targetD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= BR_BUBBLE;
    end else begin
      e_q <= e_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_br_count (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v_e),
    .count (brCount)
  );

  sat_counter #(.W(CNT_W)) u_miss_count (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mispredE),
    .count (missCount)
  );

endmodule
